// File: rtl/rr_reg_write_arbiter.sv
// rr_reg_write_arbiter
//   Round-robin arbiter that shares one WIDTH-bit register (true and complement
//   outputs) among NUM_REQ requesters. A transaction walks IDLE -> GRANT -> ACK:
//   the winner is granted, its data is written into the register, then it is
//   acknowledged with a one-cycle pulse. This block is the only writer of Q/Qbar.
//
//   Optional feature macro: RR_REG_WRITE_ARBITER_LOCK_EN
//     When defined, adds a per-requester `lock` input. A requester that holds
//     lock during its ACK cycle is re-granted at the next arbitration (if still
//     requesting), for at most 4 consecutive transactions in total.
//
// Ports
//   clock    in   rising-edge system clock
//   reset_n  in   asynchronous active-low reset
//   req      in   [NUM_REQ]        per-requester level write request
//   wdata    in   [NUM_REQ*WIDTH]  requester i data in [i*WIDTH +: WIDTH]
//   lock     in   [NUM_REQ]        (LOCK_EN builds only) re-grant request
//   gnt      out  [NUM_REQ]        registered one-hot grant
//   ack      out  [NUM_REQ]        registered one-hot write-done pulse
//   busy     out  high whenever the FSM is not idle
//   Q        out  [WIDTH]          stored register value
//   Qbar     out  [WIDTH]          bitwise complement of Q

module rr_reg_write_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] wdata,
`ifdef RR_REG_WRITE_ARBITER_LOCK_EN
    input  logic [NUM_REQ-1:0]       lock,
`endif
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     busy,
    output logic [WIDTH-1:0]         Q,
    output logic [WIDTH-1:0]         Qbar
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PtrW-1:0] PtrRst = PtrW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StAck
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;   // last committed winner
    logic [PtrW-1:0]    win_q, win_d;   // requester currently granted

    // Unpacked view of the write data bus.
    logic [WIDTH-1:0] wdata_arr [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_wdata
        assign wdata_arr[g] = wdata[g*WIDTH +: WIDTH];
    end

    // Round-robin search: first asserted req above ptr_q, wrapping.
    logic [PtrW-1:0] rr_idx;
    logic [PtrW-1:0] cand;
    logic            rr_found;

    always_comb begin
        rr_idx   = ptr_q;
        rr_found = 1'b0;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = PtrW'((32'(ptr_q) + i) % NUM_REQ);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    logic [PtrW-1:0] sel_idx;

`ifdef RR_REG_WRITE_ARBITER_LOCK_EN
    logic       lock_pend_q, lock_pend_d;  // last winner asked to keep the grant
    logic [1:0] lock_cnt_q, lock_cnt_d;    // consecutive locked re-grants so far
    logic       use_lock;

    // Three locked re-grants after the initial grant gives 4 transactions max.
    assign use_lock = lock_pend_q && req[ptr_q] && (lock_cnt_q != 2'd3);
    assign sel_idx  = use_lock ? ptr_q : rr_idx;
`else
    assign sel_idx  = rr_idx;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        ack_d   = '0;
        q_d     = q_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
`ifdef RR_REG_WRITE_ARBITER_LOCK_EN
        lock_pend_d = lock_pend_q;
        lock_cnt_d  = lock_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    win_d          = sel_idx;
                    gnt_d[sel_idx] = 1'b1;
                    state_d        = StGrant;
`ifdef RR_REG_WRITE_ARBITER_LOCK_EN
                    lock_pend_d = 1'b0;
                    lock_cnt_d  = use_lock ? lock_cnt_q + 2'd1 : 2'd0;
`endif
                end
            end
            StGrant: begin
                // Commit only if the winner is still requesting; otherwise abort.
                if (req[win_q]) begin
                    q_d          = wdata_arr[win_q];
                    ack_d[win_q] = 1'b1;
                    ptr_d        = win_q;
                    state_d      = StAck;
                end else begin
                    state_d = StIdle;
                end
            end
            StAck: begin
                state_d = StIdle;
`ifdef RR_REG_WRITE_ARBITER_LOCK_EN
                lock_pend_d = lock[ptr_q];
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            ptr_q   <= PtrRst;
            win_q   <= '0;
`ifdef RR_REG_WRITE_ARBITER_LOCK_EN
            lock_pend_q <= 1'b0;
            lock_cnt_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
`ifdef RR_REG_WRITE_ARBITER_LOCK_EN
            lock_pend_q <= lock_pend_d;
            lock_cnt_q  <= lock_cnt_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign busy = (state_q != StIdle);
    assign Q    = q_q;
    assign Qbar = ~q_q;

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Directed self-checking bench for rr_reg_write_arbiter (NUM_REQ=4, WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_rr_reg_write_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        busy;
    logic [7:0]  q;
    logic [7:0]  qbar;
`ifdef RR_REG_WRITE_ARBITER_LOCK_EN
    logic [3:0]  lock;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rr_reg_write_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .wdata   (wdata),
`ifdef RR_REG_WRITE_ARBITER_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .ack     (ack),
        .busy    (busy),
        .Q       (q),
        .Qbar    (qbar)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full transaction by requester w; called and returning at a falling edge
    // with the FSM idle. The winner drops req in its ACK cycle.
    task automatic run_txn(input string tag, input logic [3:0] req_in, input int w);
        logic [7:0] exp_q;
        logic [7:0] exp_qb;
        logic [3:0] oh;
        exp_q  = wdata[w*8 +: 8];
        exp_qb = ~exp_q;
        oh     = 4'(1 << w);
        req    = req_in;
        @(posedge clock);
        @(negedge clock);
        check({tag, " gnt"}, 32'(gnt), 32'(oh));
        check({tag, " busy_grant"}, 32'(busy), 32'd1);
        check({tag, " ack_in_grant"}, 32'(ack), 32'd0);
        @(posedge clock);
        @(negedge clock);
        check({tag, " ack"}, 32'(ack), 32'(oh));
        check({tag, " gnt_in_ack"}, 32'(gnt), 32'd0);
        check({tag, " q"}, 32'(q), 32'(exp_q));
        check({tag, " qbar"}, 32'(qbar), 32'(exp_qb));
        req[w] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check({tag, " busy_idle"}, 32'(busy), 32'd0);
        check({tag, " ack_idle"}, 32'(ack), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        req     = 4'b1111;
        wdata   = {8'h44, 8'hA5, 8'h33, 8'h11};
`ifdef RR_REG_WRITE_ARBITER_LOCK_EN
        lock    = 4'b0000;
`endif
        // Reset holds everything quiet even with all requests up.
        repeat (3) @(negedge clock);
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst ack", 32'(ack), 32'd0);
        check("rst q", 32'(q), 32'h00);
        check("rst qbar", 32'(qbar), 32'hFF);
        check("rst busy", 32'(busy), 32'd0);
        req     = 4'b0000;
        reset_n = 1'b1;
        @(negedge clock);

        // Single write from requester 2.
        run_txn("first_a5", 4'b0100, 2);

        // Round-robin from a fresh pointer: 0,1,2,3,0.
        do_reset();
        wdata = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        run_txn("rr0", 4'b1111, 0);
        run_txn("rr1", 4'b1111, 1);
        run_txn("rr2", 4'b1111, 2);
        run_txn("rr3", 4'b1111, 3);
        run_txn("rr4", 4'b1111, 0);

        // Wrap from pointer 3.
        run_txn("wrap_set", 4'b1000, 3);
        run_txn("wrap0", 4'b1001, 0);
        run_txn("wrap3", 4'b1001, 3);

        // Abort: requester 1 drops req during GRANT. Pointer stays at 3.
        req = 4'b0010;
        @(posedge clock);
        @(negedge clock);
        check("abort gnt", 32'(gnt), 32'b0010);
        req = 4'b0000;
        @(posedge clock);
        @(negedge clock);
        check("abort gnt_clr", 32'(gnt), 32'd0);
        check("abort ack", 32'(ack), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort q", 32'(q), 32'hD4);
        @(posedge clock);
        @(negedge clock);
        check("abort ack_late", 32'(ack), 32'd0);
        run_txn("abort_next", 4'b0011, 0);

        // Asynchronous reset while in GRANT (pointer 0 -> requester 2 wins).
        req = 4'b0100;
        @(posedge clock);
        @(negedge clock);
        check("arst gnt", 32'(gnt), 32'b0100);
        #1 reset_n = 1'b0;
        #1;
        check("arst gnt_clr", 32'(gnt), 32'd0);
        check("arst ack", 32'(ack), 32'd0);
        check("arst q", 32'(q), 32'h00);
        check("arst qbar", 32'(qbar), 32'hFF);
        check("arst busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        req     = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("arst no_ack", 32'(ack), 32'd0);
            check("arst q_hold", 32'(q), 32'h00);
        end

`ifdef RR_REG_WRITE_ARBITER_LOCK_EN
        // Requester 1 locked, requester 2 waiting: four wins for 1, then 2.
        do_reset();
        lock = 4'b0010;
        run_txn("lock1a", 4'b0110, 1);
        run_txn("lock1b", 4'b0110, 1);
        run_txn("lock1c", 4'b0110, 1);
        run_txn("lock1d", 4'b0110, 1);
        run_txn("lock2", 4'b0110, 2);
        lock = 4'b0000;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
